// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, operand addresses and FSM state encoding for the system
// command decoder.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_REG_WR  = 8'hAA;
   localparam logic [7:0] CMD_REG_RD  = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_ALU_A,
      ST_ALU_B,
      ST_ALU_FUN,
      ST_ALU_WAIT
   } cmd_state_e;

endpackage

// File: rtl/sys_frame_timer.sv
// Inter-byte frame timer: counts while enabled, restarts on clear, and flags
// expiry on the last count. Present only when CMD_TIMEOUT_EN is defined.
`ifdef CMD_TIMEOUT_EN
module sys_frame_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CW'(1);
   end

   // A clear in the same cycle means the frame made progress, so it wins.
   assign expire = enable & ~clear & (count == LAST);

endmodule
`endif

// File: rtl/sys_cmd_decoder.sv
// Receive-side command decoder: turns UART RX byte frames into reg-file and
// ALU operations. Define CMD_TIMEOUT_EN to add the inter-byte frame timeout.
module sys_cmd_decoder
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUN_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   input  logic                    rx_data_valid,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   input  logic                    rd_data_valid,
   input  logic [2*DATA_WIDTH-1:0] alu_out,
   input  logic                    alu_out_valid,
   output logic                    reg_wr_en,
   output logic                    reg_rd_en,
   output logic [ADDR_WIDTH-1:0]   reg_addr,
   output logic [DATA_WIDTH-1:0]   reg_wr_data,
   output logic                    alu_en,
   output logic [FUN_WIDTH-1:0]    alu_fun,
   output logic                    clk_gate_en,
   output logic                    UART_TX_REG_SEND,
   output logic                    UART_TX_ALU_SEND,
   output logic [DATA_WIDTH-1:0]   reg_data_tx,
   output logic [2*DATA_WIDTH-1:0] alu_data_tx,
   output logic                    frame_err,
   output cmd_state_e              state_dbg
);

   // Handshakes: every *_valid input is a one-cycle strobe sampled on the
   // rising edge with no back-pressure; every strobe and SEND output is a
   // one-cycle registered pulse, and its data is stable while it is high.

   cmd_state_e state_q, state_d;
   logic                    wr_en_d, rd_en_d, alu_en_d, gate_d;
   logic                    reg_send_d, alu_send_d, err_d;
   logic [ADDR_WIDTH-1:0]   addr_d;
   logic [DATA_WIDTH-1:0]   wr_data_d, reg_tx_d;
   logic [FUN_WIDTH-1:0]    fun_d;
   logic [2*DATA_WIDTH-1:0] alu_tx_d;
   logic                    timeout;

`ifdef CMD_TIMEOUT_EN
   logic tmr_clear, tmr_enable;

   // Any accepted event restarts the inter-byte window.
   assign tmr_enable = (state_q != ST_IDLE);
   assign tmr_clear  = rx_data_valid | (state_q == ST_IDLE)
                     | ((state_q == ST_RD_WAIT)  & rd_data_valid)
                     | ((state_q == ST_ALU_WAIT) & alu_out_valid);

   sys_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmr_clear),
      .enable (tmr_enable),
      .expire (timeout)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
      reg_send_d = 1'b0;
      alu_send_d = 1'b0;
      err_d      = 1'b0;
      addr_d     = reg_addr;
      wr_data_d  = reg_wr_data;
      alu_en_d   = alu_en;
      gate_d     = clk_gate_en;
      fun_d      = alu_fun;
      reg_tx_d   = reg_data_tx;
      alu_tx_d   = alu_data_tx;
      case (state_q)
         ST_IDLE: if (rx_data_valid) begin
            if (rx_data == DATA_WIDTH'(CMD_REG_WR))       state_d = ST_WR_ADDR;
            else if (rx_data == DATA_WIDTH'(CMD_REG_RD))  state_d = ST_RD_ADDR;
            else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  state_d = ST_ALU_A;
            else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ST_ALU_FUN;
         end
         ST_WR_ADDR: if (rx_data_valid) begin
            addr_d  = rx_data[ADDR_WIDTH-1:0];
            state_d = ST_WR_DATA;
         end
         ST_WR_DATA: if (rx_data_valid) begin
            wr_data_d = rx_data;
            wr_en_d   = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_RD_ADDR: if (rx_data_valid) begin
            addr_d  = rx_data[ADDR_WIDTH-1:0];
            rd_en_d = 1'b1;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: if (rd_data_valid) begin
            reg_tx_d   = rd_data;
            reg_send_d = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_ALU_A: if (rx_data_valid) begin
            addr_d    = ADDR_WIDTH'(OPA_ADDR);
            wr_data_d = rx_data;
            wr_en_d   = 1'b1;
            state_d   = ST_ALU_B;
         end
         ST_ALU_B: if (rx_data_valid) begin
            addr_d    = ADDR_WIDTH'(OPB_ADDR);
            wr_data_d = rx_data;
            wr_en_d   = 1'b1;
            state_d   = ST_ALU_FUN;
         end
         ST_ALU_FUN: if (rx_data_valid) begin
            fun_d    = rx_data[FUN_WIDTH-1:0];
            alu_en_d = 1'b1;
            gate_d   = 1'b1;
            state_d  = ST_ALU_WAIT;
         end
         ST_ALU_WAIT: if (alu_out_valid) begin
            alu_tx_d   = alu_out;
            alu_send_d = 1'b1;
            alu_en_d   = 1'b0;
            gate_d     = 1'b0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // An abandoned frame is dropped without side effects.
      if (timeout) begin
         state_d    = ST_IDLE;
         wr_en_d    = 1'b0;
         rd_en_d    = 1'b0;
         reg_send_d = 1'b0;
         alu_send_d = 1'b0;
         alu_en_d   = 1'b0;
         gate_d     = 1'b0;
         err_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_IDLE;
         reg_wr_en        <= 1'b0;
         reg_rd_en        <= 1'b0;
         reg_addr         <= '0;
         reg_wr_data      <= '0;
         alu_en           <= 1'b0;
         alu_fun          <= '0;
         clk_gate_en      <= 1'b0;
         UART_TX_REG_SEND <= 1'b0;
         UART_TX_ALU_SEND <= 1'b0;
         reg_data_tx      <= '0;
         alu_data_tx      <= '0;
         frame_err        <= 1'b0;
      end else begin
         state_q          <= state_d;
         reg_wr_en        <= wr_en_d;
         reg_rd_en        <= rd_en_d;
         reg_addr         <= addr_d;
         reg_wr_data      <= wr_data_d;
         alu_en           <= alu_en_d;
         alu_fun          <= fun_d;
         clk_gate_en      <= gate_d;
         UART_TX_REG_SEND <= reg_send_d;
         UART_TX_ALU_SEND <= alu_send_d;
         reg_data_tx      <= reg_tx_d;
         alu_data_tx      <= alu_tx_d;
         frame_err        <= err_d;
      end
   end

   assign state_dbg = state_q;

endmodule
